// File: rtl/vend_dispense_sequencer.sv
// vend_dispense_sequencer: runs the product-release motor, then pays change one hopper coin at a time.
// Every output is registered from the next-state decode, so each output lines up with its state.
module vend_dispense_sequencer #(
    parameter int MOTOR_CYCLES  = 20,
    parameter int SETTLE_CYCLES = 10,
    parameter int COIN_PULSE    = 4,
    parameter int COIN_TIMEOUT  = 50,
    parameter int COIN_VALUE    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       give,
    input  logic [1:0] product,
    input  logic [4:0] change,
    input  logic       coin_sense,
    input  logic       fault_clr,
    output logic [2:0] motor_en,
    output logic       coin_eject,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [4:0] coins_paid
);
    localparam int M1 = MOTOR_CYCLES > SETTLE_CYCLES ? MOTOR_CYCLES : SETTLE_CYCLES;
    localparam int M2 = COIN_PULSE > COIN_TIMEOUT ? COIN_PULSE : COIN_TIMEOUT;
    localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);

    typedef enum logic [2:0] {IDLE, MOTOR, SETTLE, EJECT, WAIT_COIN, DONE, FAULT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    coins_left, coins_left_n, req, paid_n;
    logic [1:0]    prod, prod_n;
    logic          sense_ok;

    assign req = 5'(32'(change) / COIN_VALUE);

    always_comb begin
        state_n      = state;
        prod_n       = prod;
        coins_left_n = coins_left;
        paid_n       = coins_paid;
        cnt_n        = (state == MOTOR || state == SETTLE || state == EJECT || state == WAIT_COIN) ? cnt + CW'(1) : '0;
        sense_ok     = coin_sense && (state == EJECT || state == WAIT_COIN) && coins_left != 5'd0;
        if (sense_ok) begin
            coins_left_n = coins_left - 5'd1;
            paid_n       = coins_paid >= 5'(30 - COIN_VALUE) ? 5'd30 : coins_paid + 5'(COIN_VALUE);
        end
        case (state)
            IDLE: begin
                if (give && (product != 2'b00 || req != 5'd0)) begin
                    prod_n       = product;
                    coins_left_n = req;
                    paid_n       = '0;
                    state_n      = product != 2'b00 ? MOTOR : EJECT;
                end
            end
            MOTOR: begin
                if (cnt == CW'(MOTOR_CYCLES - 1)) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_n = coins_left != 5'd0 ? EJECT : DONE;
                    cnt_n   = '0;
                end
            end
            EJECT: begin
                // a coin sensed mid-pulse already counts, so skip the wait when nothing is left
                if (cnt == CW'(COIN_PULSE - 1)) begin
                    state_n = coins_left_n != 5'd0 ? WAIT_COIN : DONE;
                    cnt_n   = '0;
                end
            end
            WAIT_COIN: begin
                if (sense_ok) begin
                    state_n = coins_left_n != 5'd0 ? EJECT : DONE;
                    cnt_n   = '0;
                end else if (cnt == CW'(COIN_TIMEOUT - 1)) begin
                    state_n = FAULT;
                end
            end
            DONE: state_n = IDLE;
            FAULT: begin
                if (fault_clr) begin
                    state_n      = IDLE;
                    coins_left_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            coins_left <= '0;
            prod       <= '0;
            motor_en   <= '0;
            coin_eject <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            coins_paid <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            coins_left <= coins_left_n;
            prod       <= prod_n;
            motor_en   <= state_n == MOTOR ? {prod_n == 2'd3, prod_n == 2'd2, prod_n == 2'd1} : 3'b000;
            coin_eject <= state_n == EJECT;
            busy       <= !(state_n == IDLE || state_n == DONE);
            done       <= state_n == DONE;
            fault      <= state_n == FAULT;
            coins_paid <= paid_n;
        end
    end
endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// tb_vend_dispense_sequencer: randomized and directed vends checked against a coin-count model of the sequence.
module tb_vend_dispense_sequencer;
    logic       clk = 1'b0;
    logic       reset, give, coin_sense, fault_clr;
    logic [1:0] product;
    logic [4:0] change;
    logic [2:0] motor_en;
    logic       coin_eject, busy, done, fault;
    logic [4:0] coins_paid;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    vend_dispense_sequencer dut (
        .clk(clk), .reset(reset), .give(give), .product(product), .change(change),
        .coin_sense(coin_sense), .fault_clr(fault_clr), .motor_en(motor_en),
        .coin_eject(coin_eject), .busy(busy), .done(done), .fault(fault), .coins_paid(coins_paid)
    );

    task automatic test_reset;
        reset = 1'b1; give = 1'b0; coin_sense = 1'b0; fault_clr = 1'b0; product = 2'b00; change = 5'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({motor_en, coin_eject, busy, done, fault, coins_paid} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {motor_en, coin_eject, busy, done, fault, coins_paid});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // one vend: dly<0 means the hopper never answers; early sends a sense inside every pulse
    task automatic run_vend(input logic [1:0] p, input logic [4:0] c, input int dly, input bit early,
                            input bit extra, input string tag);
        int n, exp_paid, exp_pulses, left, motor_cnt, motor_runs, pulses, run, cd, last_motor, first_post;
        bit prev_m, prev_e, seen_done, motor_bad, len_bad, done_busy, quiet_bad;
        logic [2:0] exp_oh;
        n = int'(c) / 5;
        exp_paid = n * 5 > 30 ? 30 : n * 5;
        exp_oh = p == 2'd1 ? 3'b001 : p == 2'd2 ? 3'b010 : p == 2'd3 ? 3'b100 : 3'b000;
        exp_pulses = 0;
        left = n;
        while (left > 0) begin
            exp_pulses++;
            if (early) left--;
            if (left > 0) left--;
        end
        @(negedge clk);
        give = 1'b1; product = p; change = c;
        @(negedge clk);
        give = 1'b0;
        if (p == 2'b00 && n == 0) begin
            quiet_bad = 1'b0;
            repeat (6) begin
                if (motor_en !== 3'b000 || coin_eject || busy || done || fault) quiet_bad = 1'b1;
                @(negedge clk);
            end
            total++;
            if (quiet_bad) begin
                bad++;
                $display("FAIL %s ignored_give got busy=%b eject=%b want idle", tag, busy, coin_eject);
            end
            return;
        end
        motor_cnt = 0; motor_runs = 0; pulses = 0; run = 0; cd = -1; last_motor = -1; first_post = -1;
        prev_m = 1'b0; prev_e = 1'b0; seen_done = 1'b0; motor_bad = 1'b0; len_bad = 1'b0; done_busy = 1'b0;
        for (int idx = 0; idx < 3000; idx++) begin
            if (idx > 0) @(negedge clk);
            if (motor_en !== 3'b000) begin
                motor_cnt++;
                last_motor = idx;
                if (motor_en !== exp_oh) motor_bad = 1'b1;
                if (!prev_m) motor_runs++;
            end
            if (first_post < 0 && (coin_eject || done) && (p == 2'b00 || motor_cnt > 0)) first_post = idx;
            if (coin_eject) run++;
            else if (prev_e) begin
                pulses++;
                if (run != 4) len_bad = 1'b1;
                run = 0;
                if (busy && dly >= 0) cd = dly;
            end
            coin_sense = 1'b0;
            if (early && coin_eject && run == 2) coin_sense = 1'b1;
            if (cd == 0) begin
                coin_sense = 1'b1;
                cd = -1;
            end else if (cd > 0) cd--;
            prev_m = motor_en !== 3'b000;
            prev_e = coin_eject;
            if (done) begin
                seen_done = 1'b1;
                done_busy = busy;
                break;
            end
            if (fault) break;
            give = extra && (idx % 3 == 1);
        end
        give = 1'b0; coin_sense = 1'b0;
        total++;
        if (!seen_done) begin
            bad++;
            $display("FAIL %s done_seen got fault=%b want done pulse within budget", tag, fault);
        end
        total++;
        if (motor_cnt != (p != 2'b00 ? 20 : 0) || motor_bad) begin
            bad++;
            $display("FAIL %s motor got cycles=%0d wrong_bits=%b want cycles=%0d bits=%b", tag, motor_cnt, motor_bad,
                     p != 2'b00 ? 20 : 0, exp_oh);
        end
        total++;
        if (motor_runs != (p != 2'b00 ? 1 : 0)) begin
            bad++;
            $display("FAIL %s motor_runs got=%0d want=%0d", tag, motor_runs, p != 2'b00 ? 1 : 0);
        end
        total++;
        if (pulses != exp_pulses || len_bad) begin
            bad++;
            $display("FAIL %s eject got pulses=%0d bad_len=%b want pulses=%0d", tag, pulses, len_bad, exp_pulses);
        end
        total++;
        if (coins_paid !== 5'(exp_paid)) begin
            bad++;
            $display("FAIL %s coins_paid got=%0d want=%0d", tag, coins_paid, exp_paid);
        end
        total++;
        if (seen_done && done_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_done got=%b want=0", tag, done_busy);
        end
        total++;
        if (p != 2'b00 ? (first_post - last_motor - 1 != 10) : (first_post != 0)) begin
            bad++;
            $display("FAIL %s settle_gap got first=%0d last_motor=%0d want gap 10 or immediate eject", tag,
                     first_post, last_motor);
        end
        quiet_bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (motor_en !== 3'b000 || coin_eject || busy || done || fault || coins_paid !== 5'(exp_paid))
                quiet_bad = 1'b1;
        end
        total++;
        if (quiet_bad) begin
            bad++;
            $display("FAIL %s after_done got activity/paid=%0d want idle paid=%0d", tag, coins_paid, exp_paid);
        end
    endtask

    task automatic test_reset_mid_motor;
        @(negedge clk);
        give = 1'b1; product = 2'd1; change = 5'd5;
        @(negedge clk);
        give = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (motor_en !== 3'b001) begin
            bad++;
            $display("FAIL mid_motor_pre got=%b want=001", motor_en);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (motor_en !== 3'b000 || busy !== 1'b0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got motor=%b busy=%b fault=%b want 000/0/0", motor_en, busy, fault);
        end
        @(negedge clk);
        reset = 1'b0;
        run_vend(2'd3, 5'd5, 3, 1'b0, 1'b0, "restart");
    endtask

    task automatic test_fault;
        int fall_idx, fault_idx;
        bit prev_e, hold_bad;
        fall_idx = -1; fault_idx = -1; prev_e = 1'b0;
        @(negedge clk);
        give = 1'b1; product = 2'd2; change = 5'd10;
        @(negedge clk);
        give = 1'b0;
        for (int idx = 0; idx < 400; idx++) begin
            if (idx > 0) @(negedge clk);
            if (!coin_eject && prev_e && fall_idx < 0) fall_idx = idx;
            prev_e = coin_eject;
            if (fault) begin
                fault_idx = idx;
                break;
            end
        end
        total++;
        if (fault_idx < 0 || fault_idx - fall_idx != 50) begin
            bad++;
            $display("FAIL fault_timing got fall=%0d fault=%0d want distance 50", fall_idx, fault_idx);
        end
        total++;
        if (busy !== 1'b1 || coin_eject !== 1'b0 || motor_en !== 3'b000) begin
            bad++;
            $display("FAIL fault_outputs got busy=%b eject=%b motor=%b want 1/0/000", busy, coin_eject, motor_en);
        end
        hold_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            give = k < 2;
            @(negedge clk);
            if (fault !== 1'b1 || busy !== 1'b1 || motor_en !== 3'b000 || coin_eject !== 1'b0) hold_bad = 1'b1;
        end
        give = 1'b0;
        total++;
        if (hold_bad) begin
            bad++;
            $display("FAIL fault_sticky got fault=%b busy=%b want fault held, give ignored", fault, busy);
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        total++;
        if (fault !== 1'b0 || busy !== 1'b0 || coins_paid !== 5'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear got fault=%b busy=%b paid=%0d done=%b want 0/0/0/0", fault, busy, coins_paid, done);
        end
    endtask

    task automatic test_random;
        logic [1:0] p;
        logic [4:0] c;
        for (int i = 0; i < 10; i++) begin
            p = 2'($urandom_range(0, 3));
            c = 5'($urandom_range(0, 31));
            run_vend(p, c, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_motor();
        run_vend(2'd3, 5'd5, 3, 1'b0, 1'b0, "water_5");
        run_vend(2'd0, 5'd15, 0, 1'b0, 1'b0, "cancel_15");
        run_vend(2'd1, 5'd7, 2, 1'b0, 1'b0, "lemon_7");
        run_vend(2'd2, 5'd10, 1, 1'b0, 1'b1, "give_while_busy");
        run_vend(2'd0, 5'd4, 0, 1'b0, 1'b0, "ignored_none");
        run_vend(2'd0, 5'd5, 5, 1'b1, 1'b0, "early_sense_1");
        run_vend(2'd0, 5'd10, 4, 1'b1, 1'b0, "early_sense_2");
        run_vend(2'd3, 5'd31, 45, 1'b0, 1'b0, "max_change");
        test_fault();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
